// File: rtl/input_pkg.sv
// Shared types and port-map constants for the button input path.
package input_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW,
    PEND_HIGH,
    STABLE_HIGH,
    PEND_LOW
  } deb_state_t;

  localparam logic [3:0] PORT_BUTTONS  = 4'd0;
  localparam logic [3:0] PORT_PRESSCNT = 4'd1;

  localparam int LVL_LSB     = 0;
  localparam int EVT_LSB     = 8;
  localparam int ANY_EVT_BIT = 15;
  localparam int CNT_LSB     = 0;
  localparam int CNT_W       = 8;

  // Number of simultaneous pulses; at most 7 buttons exist.
  function automatic logic [3:0] pulse_count(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser followed by a counting debounce FSM.
// lvl is registered; press_pulse flags the cycle whose edge enters STABLE_HIGH.
module button_debouncer
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic lvl,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          synced;

  assign synced = sync_q[1];

  // The sample that leaves a stable state already counts as the first of the run.
  always_comb begin
    sync_d      = {sync_q[0], btn_raw};
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_pulse = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (synced) begin
          state_d = PEND_HIGH;
          cnt_d   = CW'(1);
        end
      end
      PEND_HIGH: begin
        if (!synced) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = STABLE_HIGH;
          cnt_d       = '0;
          press_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_HIGH: begin
        if (!synced) begin
          state_d = PEND_LOW;
          cnt_d   = CW'(1);
        end
      end
      PEND_LOW: begin
        if (synced) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
    lvl_d = (state_d == STABLE_HIGH) || (state_d == PEND_LOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  end

  assign lvl = lvl_q;

endmodule

// File: rtl/input_port_ctrl.sv
// Button input port: per-button debouncers, sticky press events, press counter, CPU read mux.
// Optional auto-repeat while a button is held: define INPUT_AUTOREPEAT_EN.
module input_port_ctrl
  import input_pkg::*;
#(
  parameter int N_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] buttons,
  input  logic                 rd_en,
  input  logic [3:0]           rd_port,
  output logic [15:0]          in_data
);

  logic [N_BUTTONS-1:0] lvl;
  logic [N_BUTTONS-1:0] press_pulse;
  logic [N_BUTTONS-1:0] rep_pulse;
  logic [N_BUTTONS-1:0] pulse;
  logic [N_BUTTONS-1:0] evt_q, evt_d;
  logic [CNT_W-1:0]     press_cnt_q, press_cnt_d;
  logic                 clear_evt;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (buttons[i]),
      .lvl        (lvl[i]),
      .press_pulse(press_pulse[i])
    );
  end

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_invalid
  end

`ifdef INPUT_AUTOREPEAT_EN
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic [TW-1:0]        timer_q [N_BUTTONS];
  logic [TW-1:0]        timer_d [N_BUTTONS];
  logic [N_BUTTONS-1:0] periodic_q, periodic_d;

  // Timer counts cycles since the last press/repeat; periodic_q selects delay vs period.
  always_comb begin
    rep_pulse  = '0;
    periodic_d = periodic_q;
    for (int i = 0; i < N_BUTTONS; i++) begin
      timer_d[i] = timer_q[i];
      if (press_pulse[i] || !lvl[i]) begin
        timer_d[i]    = '0;
        periodic_d[i] = 1'b0;
      end else if (timer_q[i] == (periodic_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
        rep_pulse[i]  = 1'b1;
        timer_d[i]    = '0;
        periodic_d[i] = 1'b1;
      end else begin
        timer_d[i] = timer_q[i] + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      periodic_q <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      periodic_q <= periodic_d;
      for (int i = 0; i < N_BUTTONS; i++) begin
        timer_q[i] <= timer_d[i];
      end
    end
  end
`else
  assign rep_pulse = '0;
`endif

  assign pulse     = press_pulse | rep_pulse;
  assign clear_evt = rd_en && (rd_port == PORT_BUTTONS);

  // A fresh pulse overrides a same-cycle read-clear for that button only.
  always_comb begin
    evt_d       = (clear_evt ? '0 : evt_q) | pulse;
    press_cnt_d = press_cnt_q + {4'b0000, pulse_count(8'(pulse))};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_q       <= '0;
      press_cnt_q <= '0;
    end else begin
      evt_q       <= evt_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  always_comb begin
    in_data = '0;
    case (rd_port)
      PORT_BUTTONS: begin
        in_data[LVL_LSB +: N_BUTTONS] = lvl;
        in_data[EVT_LSB +: N_BUTTONS] = evt_q;
        in_data[ANY_EVT_BIT]          = |evt_q;
      end
      PORT_PRESSCNT: begin
        in_data[CNT_LSB +: CNT_W] = press_cnt_q;
      end
      default: begin
        in_data = '0;
      end
    endcase
  end

endmodule
